result_reader: RTL and testbench

RESULT_READER -- requirements
Module: result_reader

---
 rtl/result_reader.sv | 106 ++++++++++
 tb/tb_result_reader.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/result_reader.sv
// Streams NPIX consecutive SRAM words from BASE out over a valid/ready port.
// Reads are issued only when the 2-entry output FIFO is guaranteed room on return.
module result_reader #(
  parameter int ADDR_W = 19,
  parameter int BASE   = 262144,
  parameter int NPIX   = 260100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              csn,
  output logic              wen,
  output logic [ADDR_W-1:0] ad,
  input  logic [15:0]       dout,
  output logic [15:0]       o_data,
  output logic              o_valid,
  input  logic              o_ready,
  output logic              o_last,
  output logic              busy,
  output logic              done
);
  localparam int                CNT_W  = $clog2(NPIX + 1);
  localparam logic [CNT_W-1:0]  NPIX_C = CNT_W'(NPIX);
  localparam logic [CNT_W-1:0]  LAST_C = CNT_W'(NPIX - 1);
  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;
  logic             inflight_q;
  logic [15:0]      fifo_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q;
  logic             issue, pop, push;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = READ;
      READ:    if (issue_cnt_q == NPIX_C) state_d = DRAIN;
      DRAIN:   if (xfer_cnt_d == NPIX_C) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q == READ) || (state_q == DRAIN);
    done    = (state_q == FIN);
    o_valid = (count_q != 2'd0);
    pop     = o_valid && o_ready;
    push    = inflight_q;
    // A word leaving the FIFO this cycle frees its slot for a read issued now,
    // which is what sustains one word per cycle with only two entries.
    issue   = (state_q == READ) && (issue_cnt_q < NPIX_C) &&
              ((count_q - {1'b0, pop}) + {1'b0, inflight_q} < 2'd2);
    csn     = !issue;
    wen     = 1'b0;
    ad      = issue ? BASE_A + ADDR_W'(issue_cnt_q) : '0;
    o_data  = fifo_q[rd_ptr_q];
    o_last  = o_valid && (xfer_cnt_q == LAST_C);
  end

  always_comb begin
    issue_cnt_d = issue_cnt_q;
    xfer_cnt_d  = xfer_cnt_q;
    if (state_q == IDLE && start) begin
      issue_cnt_d = '0;
      xfer_cnt_d  = '0;
    end else begin
      if (issue) issue_cnt_d = issue_cnt_q + 1'b1;
      if (pop)   xfer_cnt_d  = xfer_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_cnt_q <= '0;
      xfer_cnt_q  <= '0;
      inflight_q  <= 1'b0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      fifo_q[0]   <= '0;
      fifo_q[1]   <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      xfer_cnt_q  <= xfer_cnt_d;
      inflight_q  <= issue;
      if (push) begin
        fifo_q[wr_ptr_q] <= dout;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_result_reader.sv
// Bench for result_reader: SRAM model returning 0x100+address, a stream-level
// reference model checked every cycle, and directed passes with literal expectations.
module tb_result_reader;
  localparam int AW   = 19;
  localparam int BASE = 16;
  localparam int NPIX = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          o_ready = 1'b0;
  logic [15:0]   dout = '0;
  logic          csn, wen, o_valid, o_last, busy, done;
  logic [AW-1:0] ad;
  logic [15:0]   o_data;

  int errors = 0;
  int checks = 0;

  result_reader #(.ADDR_W(AW), .BASE(BASE), .NPIX(NPIX)) dut (
    .clk(clk), .rst(rst), .start(start), .csn(csn), .wen(wen), .ad(ad),
    .dout(dout), .o_data(o_data), .o_valid(o_valid), .o_ready(o_ready),
    .o_last(o_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // SRAM: word at address a is 0x100 + a, returned one cycle after the read
  always @(posedge clk) if (!csn) dout <= 16'h100 + 16'(ad);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: which word of the pass is next, how many reads were issued,
  // and whether a pass is running; advanced from the handshakes seen each cycle.
  int          issue_m = 0, xfer_m = 0, since = 0;
  bit          active = 0, done_due = 0, prev_stall = 0;
  logic [15:0] prev_data = '0;
  logic        prev_last = 1'b0;

  always @(negedge clk) begin
    bit act0, xfer_now, done_next;
    check("wen_low", wen, 0);
    if (!rst) begin
      check("rst_csn", csn, 1);
      check("rst_ad", ad, 0);
      check("rst_valid", o_valid, 0);
      check("rst_last", o_last, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      issue_m = 0; xfer_m = 0; since = 0;
      active = 0; done_due = 0; prev_stall = 0;
    end else begin
      act0      = active;
      xfer_now  = o_valid && o_ready;
      done_next = 0;
      if (active && since < 4) since++;
      check("busy", busy, active);
      check("done", done, done_due);
      if (active && since == 2) check("lat_early", o_valid, 0);
      if (active && since == 3) check("lat_first", o_valid, 1);
      if (!active) check("idle_valid", o_valid, 0);
      if (prev_stall) begin
        check("stall_valid", o_valid, 1);
        check("stall_data", o_data, prev_data);
        check("stall_last", o_last, prev_last);
      end
      if (o_valid) begin
        check("data", o_data, 16'h100 + 16'(BASE + xfer_m));
        check("last", o_last, xfer_m == NPIX - 1);
      end else begin
        check("last_novalid", o_last, 0);
      end
      if (!csn) begin
        check("issue_active", active, 1);
        check("issue_limit", issue_m < NPIX, 1);
        check("ad", ad, AW'(BASE + issue_m));
        check("fifo_room", (issue_m - xfer_m - int'(xfer_now)) < 2, 1);
        issue_m++;
      end
      if (xfer_now) begin
        check("xfer_expected", active && xfer_m < NPIX, 1);
        xfer_m++;
        if (xfer_m == NPIX) begin
          active    = 0;
          done_next = 1;
        end
      end
      if (start && !act0 && !done_due) begin
        active = 1; issue_m = 0; xfer_m = 0; since = 0;
      end
      done_due   = done_next;
      prev_stall = o_valid && !o_ready;
      prev_data  = o_data;
      prev_last  = o_last;
    end
  end

  // mode 0: ready held 1; 1: ready toggles; 2: ready 0 for 20 cycles; 3: re-start mid-pass
  task automatic run_pass(input int mode, input int cycles,
                          output int nx, output int nd, output int ncs,
                          output logic [15:0] first);
    bit got_first;
    nx = 0; nd = 0; ncs = 0; first = '0; got_first = 0;
    @(posedge clk); #1;
    start = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      case (mode)
        1:       o_ready = i[0];
        2:       o_ready = (i >= 20);
        default: o_ready = 1'b1;
      endcase
      @(negedge clk);
      if (o_valid && !got_first) begin
        first = o_data;
        got_first = 1;
      end
      if (o_valid && o_ready) nx++;
      if (done) nd++;
      if (!csn) ncs++;
      if (mode == 2 && i == 19) begin
        check("stall_reads", ncs <= 2, 1);
        check("stall_csn", csn, 1);
        check("stall_head", o_data, 16'h110);
      end
      @(posedge clk); #1;
      start = (mode == 3 && i == 2);
    end
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int nx, nd, ncs, n;
    logic [15:0] first;

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);

    // Full-rate pass with literal expectations
    @(posedge clk); #1;
    o_ready = 1'b1;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t1_valid", o_valid, 1);
      check("t1_data", o_data, 32'h110 + k);
      check("t1_last", o_last, k == 3);
    end
    @(negedge clk);
    check("t1_done", done, 1);
    @(negedge clk);
    check("t1_done_once", done, 0);
    repeat (3) @(posedge clk);

    run_pass(0, 12, nx, nd, ncs, first);
    check("p0_xfers", nx, 4);
    check("p0_done", nd, 1);
    check("p0_reads", ncs, 4);
    check("p0_first", first, 16'h110);

    run_pass(1, 20, nx, nd, ncs, first);
    check("toggle_xfers", nx, 4);
    check("toggle_done", nd, 1);

    run_pass(2, 32, nx, nd, ncs, first);
    check("stall_xfers", nx, 4);
    check("stall_done", nd, 1);
    check("stall_first", first, 16'h110);

    run_pass(3, 16, nx, nd, ncs, first);
    check("restart_xfers", nx, 4);
    check("restart_done", nd, 1);

    // Reset after two transfers, then a fresh pass
    @(posedge clk); #1;
    o_ready = 1'b1;
    start   = 1'b1;
    n = 0;
    for (int i = 0; i < 20 && n < 2; i++) begin
      @(negedge clk);
      if (o_valid && o_ready) n++;
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("pre_reset_xfers", n, 2);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_reset_valid", o_valid, 0);
    run_pass(0, 12, nx, nd, ncs, first);
    check("rst_xfers", nx, 4);
    check("rst_done_cnt", nd, 1);
    check("rst_first", first, 16'h110);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
